// File: rtl/fifo_wr_arbiter_if.sv
// Requester lanes, FIFO write port and grant status shared by the write arbiter.
// slave is the arbiter's view; master is the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;

   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din, grant, busy
   );

   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_din, grant, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for one FIFO write port: 1-cycle grant latency, one IDLE bubble per grant.
// Write path is combinational from the registered grant; fifo_full stalls the burst in place.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic             clk,
   input  logic             rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;
   logic [PTR_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic                  found;
   logic [PTR_W-1:0]      win_idx;
   logic                  in_burst;
   logic                  g_valid;
   logic                  g_last;
   logic                  xfer;
   logic                  cap_hit;
   logic [DATA_WIDTH-1:0] lane_dat;

   // Cyclic search starting just after the last winner, wrapping at NUM_REQ-1.
   always_comb begin
      int sum;
      found   = 1'b0;
      win_idx = '0;
      sum     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = int'(last_q) + k;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         if (!found && bus.req_valid[sum[PTR_W-1:0]]) begin
            found   = 1'b1;
            win_idx = sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      lane_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == PTR_W'(i)) begin
            lane_dat = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign in_burst = (state_q == BURST);
   assign g_valid  = bus.req_valid[gidx_q];
   assign g_last   = bus.req_last[gidx_q];
   assign xfer     = in_burst && g_valid && !bus.fifo_full;
   // The transfer happening now is the MAX_BURST-th of this grant.
   assign cap_hit  = (cnt_q == CNT_W'(MAX_BURST - 1));

   assign bus.req_ready  = (in_burst && !bus.fifo_full) ? grant_q : '0;
   assign bus.fifo_wr_en = xfer;
   assign bus.fifo_din   = in_burst ? lane_dat : '0;
   assign bus.grant      = grant_q;
   assign bus.busy       = in_burst;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BURST;
               grant_d = NUM_REQ'(1) << win_idx;
               gidx_d  = win_idx;
               last_d  = win_idx;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (g_last || cap_hit) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= PTR_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round-robin, MAX_BURST cut,
// full back-pressure, requester stall and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
   endtask

   task automatic set_lane(input int i, input logic [DW-1:0] d);
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '1;
      bus.req_last  = '0;
      bus.req_data  = 32'hA5A5_A5A5;
      bus.fifo_full = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", bus.fifo_din); end
      clear_inputs();
      rst = 1'b0;
   endtask

   task automatic test_single();
      tick();
      bus.req_valid[2] = 1'b1;
      set_lane(2, 8'h11);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h11) begin n_bad++; $display("FAIL single_w0: got wr=%b din=%h want wr=1 din=11", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      set_lane(2, 8'h22);
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h22) begin n_bad++; $display("FAIL single_w1: got wr=%b din=%h want wr=1 din=22", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      set_lane(2, 8'h33);
      bus.req_last[2] = 1'b1;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h33) begin n_bad++; $display("FAIL single_w2: got wr=%b din=%h want wr=1 din=33", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      clear_inputs();
      #1;
      n_cmp++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_end: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL single_end_wr: got %b want 0", bus.fifo_wr_en); end
   endtask

   task automatic test_round_robin();
      int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
      logic [3:0] eg;
      logic [7:0] ed;
      tick();
      do_reset();
      bus.req_valid = 4'b1011;
      bus.req_last  = 4'b1011;
      set_lane(0, 8'hA0);
      set_lane(1, 8'hA1);
      set_lane(3, 8'hA3);
      for (int s = 0; s < 6; s++) begin
         #1;
         n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rr_bubble[%0d]: got busy=%b wr=%b want 0/0", s, bus.busy, bus.fifo_wr_en); end
         tick();
         #1;
         eg = 4'b0001 << exp_seq[s];
         ed = 8'(8'hA0 + exp_seq[s]);
         n_cmp++; if (bus.grant !== eg) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", s, bus.grant, eg); end
         n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== ed) begin n_bad++; $display("FAIL rr_data[%0d]: got wr=%b din=%h want wr=1 din=%h", s, bus.fifo_wr_en, bus.fifo_din, ed); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_max_burst();
      int p0 = 0;
      int p1 = 0;
      logic [7:0] got_d [$];
      logic [3:0] got_g [$];
      logic [7:0] exp_d [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'h04, 8'h05};
      logic [3:0] exp_g [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
      tick();
      do_reset();
      for (int cyc = 0; cyc < 40 && (p0 < 6 || p1 < 1); cyc++) begin
         bus.req_valid[0] = (p0 < 6);
         bus.req_last[0]  = (p0 == 5);
         set_lane(0, 8'(p0));
         bus.req_valid[1] = (p1 < 1);
         bus.req_last[1]  = 1'b1;
         set_lane(1, 8'h55);
         #1;
         if (bus.fifo_wr_en) begin
            got_d.push_back(bus.fifo_din);
            got_g.push_back(bus.grant);
         end
         if (bus.req_valid[0] && bus.req_ready[0]) p0++;
         if (bus.req_valid[1] && bus.req_ready[1]) p1++;
         tick();
      end
      clear_inputs();
      n_cmp++; if (p0 != 6 || p1 != 1) begin n_bad++; $display("FAIL mb_timeout: got p0=%0d p1=%0d want 6/1", p0, p1); end
      n_cmp++; if (got_d.size() != 7) begin n_bad++; $display("FAIL mb_count: got %0d writes want 7", got_d.size()); end
      for (int k = 0; k < 7; k++) begin
         n_cmp++;
         if (k >= got_d.size()) begin
            n_bad++; $display("FAIL mb_word[%0d]: got none want din=%h grant=%b", k, exp_d[k], exp_g[k]);
         end else if (got_d[k] !== exp_d[k] || got_g[k] !== exp_g[k]) begin
            n_bad++; $display("FAIL mb_word[%0d]: got din=%h grant=%b want din=%h grant=%b", k, got_d[k], got_g[k], exp_d[k], exp_g[k]);
         end
      end
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mb_end_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_full_backpressure();
      tick();
      do_reset();
      bus.req_valid[1] = 1'b1;
      set_lane(1, 8'h61);
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0010 || bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h61) begin n_bad++; $display("FAIL full_w0: got grant=%b wr=%b din=%h want 0010/1/61", bus.grant, bus.fifo_wr_en, bus.fifo_din); end
      tick();
      set_lane(1, 8'h62);
      bus.fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL full_gate[%0d]: got wr=%b ready=%b want 0/0000", c, bus.fifo_wr_en, bus.req_ready); end
         n_cmp++; if (bus.grant !== 4'b0010 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL full_hold[%0d]: got grant=%b busy=%b want 0010/1", c, bus.grant, bus.busy); end
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h62 || bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL full_resume: got wr=%b din=%h ready=%b want 1/62/0010", bus.fifo_wr_en, bus.fifo_din, bus.req_ready); end
      tick();
      set_lane(1, 8'h63);
      bus.req_last[1] = 1'b1;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h63) begin n_bad++; $display("FAIL full_w2: got wr=%b din=%h want 1/63", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      clear_inputs();
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_bad++; $display("FAIL full_end: got busy=%b grant=%b want 0/0000", bus.busy, bus.grant); end
   endtask

   task automatic test_stall();
      tick();
      do_reset();
      bus.req_valid = 4'b1101;
      bus.req_last  = 4'b1100;
      set_lane(0, 8'h71);
      set_lane(2, 8'h92);
      set_lane(3, 8'h93);
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0001 || bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h71) begin n_bad++; $display("FAIL stall_w0: got grant=%b wr=%b din=%h want 0001/1/71", bus.grant, bus.fifo_wr_en, bus.fifo_din); end
      tick();
      bus.req_valid[0] = 1'b0;
      set_lane(0, 8'h72);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (bus.fifo_wr_en !== 1'b0 || bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL stall_hold[%0d]: got wr=%b grant=%b busy=%b want 0/0001/1", c, bus.fifo_wr_en, bus.grant, bus.busy); end
         tick();
      end
      bus.req_valid[0] = 1'b1;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h72) begin n_bad++; $display("FAIL stall_w1: got wr=%b din=%h want 1/72", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      set_lane(0, 8'h73);
      bus.req_last[0] = 1'b1;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h73) begin n_bad++; $display("FAIL stall_w2: got wr=%b din=%h want 1/73", bus.fifo_wr_en, bus.fifo_din); end
      tick();
      bus.req_valid[0] = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_bad++; $display("FAIL stall_bubble: got busy=%b grant=%b want 0/0000", bus.busy, bus.grant); end
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0100 || bus.fifo_din !== 8'h92) begin n_bad++; $display("FAIL stall_next: got grant=%b din=%h want 0100/92", bus.grant, bus.fifo_din); end
      tick();
      clear_inputs();
   endtask

   task automatic test_async_reset();
      tick();
      do_reset();
      bus.req_valid[1] = 1'b1;
      set_lane(1, 8'h81);
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0010 || bus.busy !== 1'b1 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got grant=%b busy=%b wr=%b want 0010/1/1", bus.grant, bus.busy, bus.fifo_wr_en); end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_state: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== 8'h00 || bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL arst_out: got wr=%b din=%h ready=%b want 0/00/0000", bus.fifo_wr_en, bus.fifo_din, bus.req_ready); end
      #1;
      rst = 1'b0;
      clear_inputs();
      bus.req_valid = 4'b0101;
      bus.req_last  = 4'b0101;
      tick();
      #1;
      n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL arst_prio: got grant=%b want 0001", bus.grant); end
      tick();
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_max_burst();
      test_full_backpressure();
      test_stall();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one synchronous FIFO among `NUM_REQ` requesters. Each requester offers a burst of words over a valid/ready handshake. The arbiter locks the grant for the whole burst and forwards the granted requester's data straight to the FIFO write port, respecting FIFO full back-pressure. It sits in front of the team's sync FIFO wherever several producers feed one buffer.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: word width; must match the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum words per grant, at least 1; forces rotation so no requester starves the others.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `req_valid` input, `NUM_REQ`: requester i has a word on its data lane.
- `req_last` input, `NUM_REQ`: the current word of requester i ends its burst.
- `req_data` input, `NUM_REQ*DATA_WIDTH`: flattened data; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` output, `NUM_REQ`: the word of requester i is accepted this cycle.
- `fifo_full` input, 1: driven from the FIFO's `full`.
- `fifo_wr_en` output, 1: drives the FIFO's `wr_en`.
- `fifo_din` output, `DATA_WIDTH`: drives the FIFO's `din`.
- `grant` output, `NUM_REQ`: one-hot registered grant, or all zeros when idle.
- `busy` output, 1: high in BURST state.

## Operation
- There are two FSM states, IDLE and BURST.
- **Reset values:**
  - state is IDLE;
  - `grant` is 0;
  - `busy` is 0;
  - `req_ready`, `fifo_wr_en` and `fifo_din` are 0;
  - burst counter is 0;
  - last-winner pointer is `NUM_REQ-1`, so requester 0 has highest priority first.
- **IDLE:**
  - If any `req_valid` is high, select the first requester with valid high, searching cyclically from last-winner+1.
  - Register the winner into `grant` and the last-winner pointer, clear the burst counter, and go to BURST.
  - If no `req_valid` is high, stay in IDLE.
  - `req_last` is ignored in IDLE.
- **Acceptance:**
  - Acceptance is combinational, and happens only in BURST for granted requester g.
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[g] && !fifo_full`.
  - `fifo_din` = lane g whenever in BURST, and 0 in IDLE.
  - A word transfers when `req_valid[g] && req_ready[g]`.
- **BURST, per transfer:**
  - The burst counter increments.
  - If `req_last[g]` is high, or the counter reaches `MAX_BURST` with this transfer, go to IDLE next cycle and clear `grant`.
  - Otherwise stay in BURST.
- **Stall in BURST:**
  - If `req_valid[g]` is low, or `fifo_full` is high, no transfer occurs and the grant is held.
  - There is no timeout. Requesters must complete bursts they start.
- **Forced rotation:** a burst cut by `MAX_BURST` resumes in a later grant. `req_last` is then still pending in the requester's stream.
- **Counter width:** `$clog2(MAX_BURST+1)` bits; it never wraps.
- **Pointer wrap:** the cyclic search wraps from `NUM_REQ-1` to 0.

## Timing
- **Arbitration latency:** 1 cycle. A request in IDLE at edge N gives `grant`/`busy` high after edge N, so the first transfer is possible in cycle N+1.
- **Bubble:** exactly one IDLE cycle between consecutive grants. This gives peak throughput of `MAX_BURST/(MAX_BURST+1)` under continuous requests.
- **Throughput within a burst:** one word per cycle while `!fifo_full`.
- **Full handling:**
  - `fifo_full` gates `fifo_wr_en` in the same cycle; the arbiter never asserts write while full.
  - The FIFO drops writes while full, so this gating is mandatory.
- **Data path:** `fifo_din`/`fifo_wr_en` are combinational from the inputs and the registered grant. The FIFO samples them at the next edge.
- **Simultaneous events:**
  - A last word accepted in the same cycle a new request rises: that request is evaluated in the following IDLE cycle.
  - Other requesters' `req_valid` changes during BURST have no effect.
- **Reset mid-burst:**
  - `rst` immediately forces all outputs to their reset values, asynchronously.
  - A partial burst already written to the FIFO stays there. The FIFO is reset by the same `rst`.

## Test plan
- **Single requester:**
  - Stimulus: after reset, req 2 sends 3 words 0x11, 0x22, 0x33, with last on 0x33.
  - Response: `grant`=0100 one cycle after valid; `fifo_wr_en` for 3 consecutive cycles with `fifo_din` 0x11, 0x22, 0x33; then IDLE, with `grant`=0 and `busy`=0.
- **Round-robin:**
  - Stimulus: reqs 0, 1 and 3 continuously valid with 1-word bursts.
  - Response: grant order 0, 1, 3, 0, 1, 3…; one IDLE cycle between grants; req 2 never granted.
- **MAX_BURST cut:**
  - Stimulus: req 0 sends a 6-word burst while req 1 is also valid.
  - Response: 4 words from req 0, then req 1's burst, then req 0's remaining 2 words ending on last.
- **Full back-pressure:**
  - Stimulus: `fifo_full` held high for 3 cycles mid-burst.
  - Response: `fifo_wr_en`=0 and `req_ready[g]`=0 for those cycles; grant held; burst resumes with no word lost or duplicated.
- **Requester stall:**
  - Stimulus: granted requester drops `req_valid` for 2 cycles mid-burst while others request.
  - Response: grant unchanged and no writes during the stall; burst continues when valid returns.
- **Async reset:**
  - Stimulus: `rst` pulsed between clock edges during a burst.
  - Response: `grant`, `busy` and `fifo_wr_en` go to 0 before the next edge; the next arbitration favours req 0.
